// File: rtl/lane_traffic_gen.sv
// lane_traffic_gen
//   Car-lane generator for the playfield. Every tick, each lane scrolls by one
//   column. A new entry bit is shifted in from the spawn logic for that lane.
//   Difficulty affects the game in two ways. It shortens the tick period, and it
//   raises the chance that a free lane spawns a car. A reset_playfield pulse
//   clears all lanes and timers and restarts the grace period. It does not
//   reseed the LFSR, so each round after the first gets a different sequence.
//
//   Optional build macro:
//     LANE_ALT_DIR_EN - odd lanes scroll right (entry bit COLS-1, exit bit 0);
//                       when undefined, all lanes scroll left (entry bit 0).
//
//   Ports:
//     clk              in   1            system clock
//     reset            in   1            synchronous, active-high; full init incl. LFSR seed
//     reset_playfield  in   1            synchronous clear of lanes/timers; LFSR kept
//     difficulty       in   3            0..7, sampled every cycle
//     pause            in   1            freezes tick counter and lanes
//     lane_pattern     out  LANES*COLS   lane i = bits [i*COLS +: COLS]; 1 = car
//     step             out  1            one-cycle pulse after each tick's shift
//     in_grace         out  1            high while spawning is held off
module lane_traffic_gen #(
    parameter int LANES       = 4,
    parameter int COLS        = 16,
    parameter int BASE_PERIOD = 1024,
    parameter int CAR_LEN     = 2,
    parameter int MIN_GAP     = 2,
    parameter int GRACE_TICKS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   reset_playfield,
    input  logic [2:0]             difficulty,
    input  logic                   pause,
    output logic [LANES*COLS-1:0]  lane_pattern,
    output logic                   step,
    output logic                   in_grace
);

    localparam int TICK_W  = $clog2(BASE_PERIOD);
    localparam int RUN_MAX = (CAR_LEN > MIN_GAP) ? CAR_LEN : MIN_GAP;
    localparam int CNT_W   = $clog2(RUN_MAX + 1);
    localparam int GRACE_W = (GRACE_TICKS > 1) ? $clog2(GRACE_TICKS) : 1;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic {GRACE, RUN} state_t;

    state_t                 state, state_nxt;
    logic [GRACE_W-1:0]     grace_cnt, grace_nxt;
    logic [TICK_W-1:0]      tick_cnt;
    logic [31:0]            period_full;
    logic                   tick_p0;
    logic [15:0]            lfsr, lfsr_nxt;
    logic [CNT_W-1:0]       run_cnt [LANES];
    logic [CNT_W-1:0]       gap_cnt [LANES];
    logic [CNT_W-1:0]       run_nxt [LANES];
    logic [CNT_W-1:0]       gap_nxt [LANES];
    logic [LANES-1:0]       entry;
    logic [LANES*COLS-1:0]  lane_nxt;

    // Stage p0: tick decision from the running count and the current period.
    // High difficulty can shift the period down to zero, which is clamped to one
    // (a tick every cycle). The >= compare makes a mid-count period drop tick at
    // once instead of wrapping around.
    always_comb begin
        period_full = 32'(BASE_PERIOD) >> difficulty;
        if (period_full == 32'd0)
            period_full = 32'd1;
        tick_p0  = !pause && (32'(tick_cnt) >= (period_full - 32'd1));
        lfsr_nxt = lfsr[0] ? ((lfsr >> 1) ^ LFSR_MASK) : (lfsr >> 1);
    end

    always_comb begin
        entry    = '0;
        run_nxt  = run_cnt;
        gap_nxt  = gap_cnt;
        lane_nxt = lane_pattern;
        for (int i = 0; i < LANES; i++) begin
            if (run_cnt[i] != '0) begin
                entry[i]   = 1'b1;
                run_nxt[i] = run_cnt[i] - CNT_W'(1);
                if (run_cnt[i] == CNT_W'(1))
                    gap_nxt[i] = CNT_W'(MIN_GAP);
            end else if (gap_cnt[i] != '0) begin
                gap_nxt[i] = gap_cnt[i] - CNT_W'(1);
            end else if (state == RUN && lfsr[4*i +: 3] <= difficulty) begin
                entry[i]   = 1'b1;
                run_nxt[i] = CNT_W'(CAR_LEN - 1);
            end
`ifdef LANE_ALT_DIR_EN
            if ((i % 2) == 1)
                lane_nxt[i*COLS +: COLS] = {entry[i], lane_pattern[i*COLS+1 +: COLS-1]};
            else
`endif
                lane_nxt[i*COLS +: COLS] = {lane_pattern[i*COLS +: COLS-1], entry[i]};
        end
    end

    always_comb begin
        state_nxt = state;
        grace_nxt = grace_cnt;
        case (state)
            GRACE: begin
                if (tick_p0) begin
                    if (grace_cnt == GRACE_W'(GRACE_TICKS - 1))
                        state_nxt = RUN;
                    else
                        grace_nxt = grace_cnt + GRACE_W'(1);
                end
            end
            RUN: state_nxt = RUN;
            default: state_nxt = GRACE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || reset_playfield) begin
            state     <= GRACE;
            grace_cnt <= '0;
        end else begin
            state     <= state_nxt;
            grace_cnt <= grace_nxt;
        end
    end

    // Stage p1: registered lanes, step and in_grace, all updated on the same
    // edge so that a shifted pattern and its step pulse become visible together.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else if (!reset_playfield && tick_p0) begin
            lfsr <= lfsr_nxt;
        end

        if (reset || reset_playfield) begin
            tick_cnt     <= '0;
            lane_pattern <= '0;
            step         <= 1'b0;
            in_grace     <= 1'b1;
            for (int i = 0; i < LANES; i++) begin
                run_cnt[i] <= '0;
                gap_cnt[i] <= '0;
            end
        end else begin
            step     <= tick_p0;
            in_grace <= (state_nxt == GRACE);
            if (tick_p0) begin
                tick_cnt     <= '0;
                lane_pattern <= lane_nxt;
                run_cnt      <= run_nxt;
                gap_cnt      <= gap_nxt;
            end else if (!pause) begin
                tick_cnt <= tick_cnt + TICK_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_lane_traffic_gen.sv
// Testbench for lane_traffic_gen with BASE_PERIOD=8, LANES=4, COLS=16,
// CAR_LEN=2, MIN_GAP=2, GRACE_TICKS=4. The LFSR is modelled in the bench.
// Lanes are predicted from directed entry sequences. Build with
// LANE_ALT_DIR_EN defined to exercise odd lanes that scroll right.
module tb_lane_traffic_gen;

    localparam int LANES       = 4;
    localparam int COLS        = 16;
    localparam int BASE_PERIOD = 8;
`ifdef LANE_ALT_DIR_EN
    localparam bit ALT_DIR = 1'b1;
`else
    localparam bit ALT_DIR = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  reset_playfield;
    logic [2:0]            difficulty;
    logic                  pause;
    logic [LANES*COLS-1:0] lane_pattern;
    logic                  step;
    logic                  in_grace;

    int total = 0;
    int bad   = 0;

    logic [COLS-1:0] exp_lane [LANES];
    logic [15:0]     exp_lfsr;

    lane_traffic_gen #(
        .LANES(LANES), .COLS(COLS), .BASE_PERIOD(BASE_PERIOD),
        .CAR_LEN(2), .MIN_GAP(2), .GRACE_TICKS(4)
    ) dut (
        .clk(clk), .reset(reset), .reset_playfield(reset_playfield),
        .difficulty(difficulty), .pause(pause),
        .lane_pattern(lane_pattern), .step(step), .in_grace(in_grace)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic logic [COLS-1:0] shift_lane(input logic [COLS-1:0] v, input logic e, input int lane);
        if (ALT_DIR && (lane % 2) == 1)
            return {e, v[COLS-1:1]};
        return {v[COLS-2:0], e};
    endfunction

    function automatic logic [LANES*COLS-1:0] pack_exp();
        logic [LANES*COLS-1:0] p;
        for (int i = 0; i < LANES; i++) p[i*COLS +: COLS] = exp_lane[i];
        return p;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < LANES; i++) exp_lane[i] = '0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; reset_playfield = 1'b0; pause = 1'b0; difficulty = 3'd0;
        cycle();
        cycle();
        reset = 1'b0;
        exp_lfsr = 16'hACE1;
        clear_model();
        total++; if (lane_pattern !== '0) begin bad++; $display("FAIL reset_lanes got=%h want=0", lane_pattern); end
        total++; if (step !== 1'b0) begin bad++; $display("FAIL reset_step got=%b want=0", step); end
        total++; if (in_grace !== 1'b1) begin bad++; $display("FAIL reset_in_grace got=%b want=1", in_grace); end
        total++; if (dut.lfsr !== exp_lfsr) begin bad++; $display("FAIL reset_lfsr got=%h want=%h", dut.lfsr, exp_lfsr); end
    endtask

    // d=0: a tick every 8 clocks; the first four ticks stay in grace with empty lanes.
    task automatic test_grace();
        for (int n = 1; n <= 32; n++) begin
            cycle();
            if (n % 8 == 0) exp_lfsr = lfsr_adv(exp_lfsr);
            total++; if (step !== (n % 8 == 0)) begin bad++; $display("FAIL grace_step clk=%0d got=%b want=%b", n, step, (n % 8 == 0)); end
            total++; if (in_grace !== (n < 32)) begin bad++; $display("FAIL grace_flag clk=%0d got=%b want=%b", n, in_grace, (n < 32)); end
            total++; if (lane_pattern !== '0) begin bad++; $display("FAIL grace_lanes clk=%0d got=%h want=0", n, lane_pattern); end
        end
    endtask

    // d=7: a tick every clock; every lane spawns back-to-back 1100 1100 ...
    task automatic test_max_difficulty();
        difficulty = 3'd7;
        for (int k = 0; k < 24; k++) begin
            cycle();
            for (int i = 0; i < LANES; i++) exp_lane[i] = shift_lane(exp_lane[i], (k % 4) < 2, i);
            exp_lfsr = lfsr_adv(exp_lfsr);
            total++; if (step !== 1'b1) begin bad++; $display("FAIL d7_step tick=%0d got=%b want=1", k, step); end
            total++; if (lane_pattern !== pack_exp()) begin bad++; $display("FAIL d7_lanes tick=%0d got=%h want=%h", k, lane_pattern, pack_exp()); end
            total++; if (in_grace !== 1'b0) begin bad++; $display("FAIL d7_in_grace tick=%0d got=%b want=0", k, in_grace); end
        end
        total++; if (dut.lfsr !== exp_lfsr) begin bad++; $display("FAIL d7_lfsr got=%h want=%h", dut.lfsr, exp_lfsr); end
    endtask

    // Count to 3, hold pause for 20 clocks, then the tick arrives 5 clocks after release.
    task automatic test_pause();
        logic e;
        difficulty = 3'd0;
        for (int n = 0; n < 3; n++) begin
            cycle();
            total++; if (step !== 1'b0) begin bad++; $display("FAIL prepause_step clk=%0d got=%b want=0", n, step); end
        end
        pause = 1'b1;
        for (int n = 0; n < 20; n++) begin
            cycle();
            total++; if (step !== 1'b0) begin bad++; $display("FAIL pause_step clk=%0d got=%b want=0", n, step); end
            total++; if (lane_pattern !== pack_exp()) begin bad++; $display("FAIL pause_lanes clk=%0d got=%h want=%h", n, lane_pattern, pack_exp()); end
        end
        pause = 1'b0;
        for (int n = 0; n < 4; n++) begin
            cycle();
            total++; if (step !== 1'b0) begin bad++; $display("FAIL resume_step clk=%0d got=%b want=0", n, step); end
        end
        cycle();
        for (int i = 0; i < LANES; i++) begin
            e = (exp_lfsr[4*i +: 3] == 3'd0);
            exp_lane[i] = shift_lane(exp_lane[i], e, i);
        end
        exp_lfsr = lfsr_adv(exp_lfsr);
        total++; if (step !== 1'b1) begin bad++; $display("FAIL resume_tick_step got=%b want=1", step); end
        total++; if (lane_pattern !== pack_exp()) begin bad++; $display("FAIL resume_lanes got=%h want=%h", lane_pattern, pack_exp()); end
    endtask

    // reset_playfield on a cycle that would tick: clear wins, and the LFSR holds.
    task automatic test_playfield_clear();
        difficulty = 3'd7;
        reset_playfield = 1'b1;
        cycle();
        reset_playfield = 1'b0;
        clear_model();
        total++; if (lane_pattern !== '0) begin bad++; $display("FAIL clear_lanes got=%h want=0", lane_pattern); end
        total++; if (step !== 1'b0) begin bad++; $display("FAIL clear_step got=%b want=0", step); end
        total++; if (in_grace !== 1'b1) begin bad++; $display("FAIL clear_in_grace got=%b want=1", in_grace); end
        total++; if (dut.lfsr !== exp_lfsr) begin bad++; $display("FAIL clear_lfsr got=%h want=%h", dut.lfsr, exp_lfsr); end
    endtask

    // tick_cnt=5 at d=0, then d=3 (P=1): tick immediately, then every cycle.
    task automatic test_difficulty_drop();
        logic e;
        difficulty = 3'd0;
        for (int n = 0; n < 5; n++) begin
            cycle();
            total++; if (step !== 1'b0) begin bad++; $display("FAIL drop_pre_step clk=%0d got=%b want=0", n, step); end
        end
        difficulty = 3'd3;
        for (int n = 1; n <= 4; n++) begin
            cycle();
            exp_lfsr = lfsr_adv(exp_lfsr);
            total++; if (step !== 1'b1) begin bad++; $display("FAIL drop_step tick=%0d got=%b want=1", n, step); end
            total++; if (in_grace !== (n < 4)) begin bad++; $display("FAIL drop_in_grace tick=%0d got=%b want=%b", n, in_grace, (n < 4)); end
            total++; if (lane_pattern !== '0) begin bad++; $display("FAIL drop_lanes tick=%0d got=%h want=0", n, lane_pattern); end
        end
        total++; if (dut.lfsr !== exp_lfsr) begin bad++; $display("FAIL drop_lfsr got=%h want=%h", dut.lfsr, exp_lfsr); end
        cycle();
        for (int i = 0; i < LANES; i++) begin
            e = (exp_lfsr[4*i +: 3] <= 3'd3);
            exp_lane[i] = shift_lane(exp_lane[i], e, i);
        end
        exp_lfsr = lfsr_adv(exp_lfsr);
        total++; if (step !== 1'b1) begin bad++; $display("FAIL d3_spawn_step got=%b want=1", step); end
        total++; if (lane_pattern !== pack_exp()) begin bad++; $display("FAIL d3_spawn_lanes got=%h want=%h", lane_pattern, pack_exp()); end
    endtask

    task automatic test_reset_reseed();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        total++; if (dut.lfsr !== 16'hACE1) begin bad++; $display("FAIL reseed_lfsr got=%h want=ace1", dut.lfsr); end
        total++; if (lane_pattern !== '0) begin bad++; $display("FAIL reseed_lanes got=%h want=0", lane_pattern); end
        total++; if (in_grace !== 1'b1) begin bad++; $display("FAIL reseed_in_grace got=%b want=1", in_grace); end
        total++; if (step !== 1'b0) begin bad++; $display("FAIL reseed_step got=%b want=0", step); end
    endtask

    initial begin
        test_reset();
        test_grace();
        test_max_difficulty();
        test_pause();
        test_playfield_clear();
        test_difficulty_drop();
        test_reset_reseed();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
